// File: rtl/weight_loader_if.sv
// Handshake and memory/weight bus between the weight controller, weight memory and weight_loader.
interface weight_loader_if #(
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 12
);
  logic                      rewind;
  logic                      load_start;
  logic                      load_done;
  logic                      busy;
  logic                      mem_en;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [4*WEIGHT_WIDTH-1:0] mem_rdata;
  logic [9*WEIGHT_WIDTH-1:0] weight0;
  logic [9*WEIGHT_WIDTH-1:0] weight1;
  logic [9*WEIGHT_WIDTH-1:0] weight2;
  logic [9*WEIGHT_WIDTH-1:0] weight3;

  modport master (
    output rewind, load_start, mem_rdata,
    input  load_done, busy, mem_en, mem_addr, weight0, weight1, weight2, weight3
  );

  modport slave (
    input  rewind, load_start, mem_rdata,
    output load_done, busy, mem_en, mem_addr, weight0, weight1, weight2, weight3
  );
endinterface

// File: rtl/weight_loader.sv
// Streams one 4-kernel 3x3 weight set (9 memory words) into a shadow buffer and
// publishes it atomically on the weight buses with a one-cycle load_done pulse.
module weight_loader #(
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned NUM_SETS     = 16
) (
  input logic           clk,
  input logic           rst,
  weight_loader_if.slave bus
);
  localparam int unsigned WORD_W     = 4 * WEIGHT_WIDTH;
  localparam int unsigned KERN_W     = 9 * WEIGHT_WIDTH;
  localparam int unsigned SET_W      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int unsigned SET_STRIDE = 9;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state;
  logic                    ls_prev;
  logic                    pending;
  logic                    rd_valid;
  logic [3:0]              cnt;
  logic [3:0]              rd_pos;
  logic [ADDR_WIDTH-1:0]   base;
  logic [SET_W-1:0]        set_idx;
  logic [8:0][WORD_W-1:0]  shadow;

  logic                    start_evt;
  logic [8:0][WORD_W-1:0]  shadow_next;
  logic [3:0][KERN_W-1:0]  kern_next;
  logic [ADDR_WIDTH-1:0]   base_next;
  logic [SET_W-1:0]        set_next;

  assign start_evt = bus.load_start & ~ls_prev;

  // Word returned this cycle belongs to the address issued one cycle earlier.
  always_comb begin
    shadow_next = shadow;
    if (rd_valid) shadow_next[rd_pos] = bus.mem_rdata;
  end

  // Transpose words into kernels: byte k of word p is kernel k, position p.
  always_comb begin
    kern_next = '0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 9; p++) begin
        kern_next[k][p*WEIGHT_WIDTH +: WEIGHT_WIDTH] = shadow_next[p][k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  always_comb begin
    if (set_idx == SET_W'(NUM_SETS - 1)) begin
      base_next = '0;
      set_next  = '0;
    end else begin
      base_next = base + ADDR_WIDTH'(SET_STRIDE);
      set_next  = set_idx + SET_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ls_prev       <= 1'b0;
      pending       <= 1'b0;
      rd_valid      <= 1'b0;
      cnt           <= '0;
      rd_pos        <= '0;
      base          <= '0;
      set_idx       <= '0;
      shadow        <= '0;
      bus.load_done <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.weight0   <= '0;
      bus.weight1   <= '0;
      bus.weight2   <= '0;
      bus.weight3   <= '0;
    end else begin
      ls_prev       <= bus.load_start;
      bus.load_done <= 1'b0;
      rd_valid      <= bus.mem_en;
      rd_pos        <= cnt;
      shadow        <= shadow_next;
      if (bus.rewind) begin
        // Abort whatever is in flight; a coincident start begins at set 0.
        base     <= '0;
        set_idx  <= '0;
        pending  <= 1'b0;
        rd_valid <= 1'b0;
        cnt      <= '0;
        if (start_evt) begin
          state        <= READ;
          bus.busy     <= 1'b1;
          bus.mem_en   <= 1'b1;
          bus.mem_addr <= '0;
        end else begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.mem_en <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_evt) begin
              state        <= READ;
              bus.busy     <= 1'b1;
              bus.mem_en   <= 1'b1;
              bus.mem_addr <= base;
              cnt          <= '0;
            end
          end
          READ: begin
            if (start_evt) pending <= 1'b1;
            if (cnt == 4'd8) begin
              state      <= DRAIN;
              bus.mem_en <= 1'b0;
            end else begin
              cnt          <= cnt + 4'd1;
              bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(1);
            end
          end
          DRAIN: begin
            if (start_evt) pending <= 1'b1;
            state         <= DONE;
            bus.load_done <= 1'b1;
            bus.weight0   <= kern_next[0];
            bus.weight1   <= kern_next[1];
            bus.weight2   <= kern_next[2];
            bus.weight3   <= kern_next[3];
          end
          DONE: begin
            base    <= base_next;
            set_idx <= set_next;
            if (pending || start_evt) begin
              state        <= READ;
              pending      <= 1'b0;
              bus.mem_en   <= 1'b1;
              bus.mem_addr <= base_next;
              cnt          <= '0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
